// File: rtl/spi_pwm_cmd_rx.sv
// ============================================================================
//  Module      : spi_pwm_cmd_rx
//  Description : Mode-0 SPI slave that validates 8-bit PWM command frames,
//                strobes pset/addr/level, counts bad frames, returns status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_pwm_cmd_rx #(
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             pset,
  output logic [2:0]       addr,
  output logic [2:0]       level,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [ERR_W-1:0] c_err_one = {{(ERR_W-1){1'b0}}, 1'b1};

  logic             r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic             r_cs_s1, r_cs_s2;
  logic             r_mosi_s1, r_mosi_s2;
  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_frame_done;
  logic             r_trunc;
  logic [7:0]       r_miso_sr;
  logic [2:0]       r_miso_cnt;
  logic             r_pset;
  logic [2:0]       r_addr;
  logic [2:0]       r_level;
  logic             r_frame_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_miso;

  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic [2:0]       w_cnt_next;
  logic [2:0]       w_cnt_eff;
  logic             w_frame_ok;
  logic             w_err_event;
  logic             w_err_sat;
  logic [3:0]       w_err4;
  logic [7:0]       w_status;

  generate
    if (ERR_W >= 4) begin : g_err_trunc
      assign w_err4 = r_err_cnt[3:0];
    end else begin : g_err_ext
      assign w_err4 = {{(4-ERR_W){1'b0}}, r_err_cnt};
    end
  endgenerate

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_cnt_next  = r_bit_cnt + 3'd1;
  // A rise landing in the same cycle as the CS rise still counts toward the frame.
  assign w_cnt_eff   = w_sclk_rise ? w_cnt_next : r_bit_cnt;
  assign w_frame_ok  = r_shift[7] & ~(^r_shift);
  assign w_err_event = (r_frame_done & ~w_frame_ok) | r_trunc;
  assign w_err_sat   = &r_err_cnt;
  assign w_status    = {w_err4, r_addr, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1    <= 1'b0;
      r_sclk_s2    <= 1'b0;
      r_sclk_s3    <= 1'b0;
      r_cs_s1      <= 1'b1;
      r_cs_s2      <= 1'b1;
      r_mosi_s1    <= 1'b0;
      r_mosi_s2    <= 1'b0;
      r_state      <= ST_IDLE;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_frame_done <= 1'b0;
      r_trunc      <= 1'b0;
      r_miso_sr    <= 8'h00;
      r_miso_cnt   <= 3'd0;
      r_pset       <= 1'b0;
      r_addr       <= 3'd0;
      r_level      <= 3'd0;
      r_frame_err  <= 1'b0;
      r_err_cnt    <= '0;
      r_miso       <= 1'b0;
    end else begin
      r_sclk_s1    <= spi_sclk;
      r_sclk_s2    <= r_sclk_s1;
      r_sclk_s3    <= r_sclk_s2;
      r_cs_s1      <= spi_cs_n;
      r_cs_s2      <= r_cs_s1;
      r_mosi_s1    <= spi_mosi;
      r_mosi_s2    <= r_mosi_s1;

      r_frame_done <= 1'b0;
      r_trunc      <= 1'b0;
      r_pset       <= 1'b0;
      r_frame_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= 3'd0;
          if (!r_cs_s2) begin
            r_state    <= ST_SHIFT;
            r_miso_sr  <= w_status;
            r_miso_cnt <= 3'd0;
          end
        end
        ST_SHIFT: begin
          if (w_sclk_rise) begin
            r_shift      <= {r_shift[6:0], r_mosi_s2};
            r_bit_cnt    <= w_cnt_next;
            r_frame_done <= (r_bit_cnt == 3'd7);
          end
          if (w_sclk_fall) begin
            if (r_miso_cnt == 3'd7) begin
              r_miso_sr <= w_status;
            end else begin
              r_miso_sr <= {r_miso_sr[6:0], 1'b0};
            end
            r_miso_cnt <= r_miso_cnt + 3'd1;
          end
          if (r_cs_s2) begin
            r_state   <= ST_IDLE;
            r_trunc   <= (w_cnt_eff != 3'd0);
            r_bit_cnt <= 3'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Evaluated one cycle after the shift so the complete byte is in r_shift.
      if (r_frame_done && w_frame_ok) begin
        r_pset  <= 1'b1;
        r_addr  <= r_shift[6:4];
        r_level <= r_shift[3:1];
      end

      if (w_err_event) begin
        r_frame_err <= 1'b1;
        if (!w_err_sat) begin
          r_err_cnt <= r_err_cnt + c_err_one;
        end
      end

      r_miso <= (r_state == ST_SHIFT) ? r_miso_sr[7] : 1'b0;
    end
  end

  assign spi_miso  = r_miso;
  assign pset      = r_pset;
  assign addr      = r_addr;
  assign level     = r_level;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spi_pwm_cmd_rx.sv
// ============================================================================
//  Module      : tb_spi_pwm_cmd_rx
//  Description : Directed self-checking bench for spi_pwm_cmd_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_pwm_cmd_rx;

  localparam int ERR_W = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             spi_sclk = 1'b0;
  logic             spi_cs_n = 1'b1;
  logic             spi_mosi = 1'b0;
  logic             spi_miso;
  logic             pset;
  logic [2:0]       addr;
  logic [2:0]       level;
  logic             frame_err;
  logic [ERR_W-1:0] err_cnt;

  int n_checks  = 0;
  int n_pass    = 0;
  int pset_seen = 0;
  int ferr_seen = 0;
  bit both_seen = 1'b0;

  always #5 clk = ~clk;

  spi_pwm_cmd_rx #(.ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .pset      (pset),
    .addr      (addr),
    .level     (level),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always @(negedge clk) begin
    if (pset)              pset_seen++;
    if (frame_err)         ferr_seen++;
    if (pset && frame_err) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Master samples MISO just before raising sclk, as a mode-0 master would.
  task automatic spi_bit(input logic b, output logic m);
    @(negedge clk);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] m);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], m[i]);
  endtask

  task automatic cs_fall();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_rise();
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] m2;
    logic [7:0] frame;
    int         p0;
    int         f0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_pset", pset, 0);
    check("rst_addr", addr, 0);
    check("rst_level", level, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_miso", spi_miso, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_pset", pset_seen, 0);
    check("idle_ferr", ferr_seen, 0);

    // Valid 0xD7 with cycle-exact latency check on the last bit
    frame = 8'hD7;
    cs_fall();
    for (int i = 7; i >= 1; i--) spi_bit(frame[i], m[i]);
    @(negedge clk);
    spi_mosi = frame[0];
    repeat (4) @(negedge clk);
    m[0] = spi_miso;
    spi_sclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 check("pset_early", pset, 0);
    @(posedge clk);
    #1;
    check("pset_n3", pset, 1);
    check("addr_n3", addr, 5);
    check("level_n3", level, 3);
    @(posedge clk);
    #1 check("pset_width", pset, 0);
    repeat (2) @(negedge clk);
    spi_sclk = 1'b0;
    cs_rise();
    check("d7_miso", m, 8'h01);
    check("d7_pset_cnt", pset_seen, 1);
    check("d7_err_cnt", err_cnt, 0);
    check("d7_ferr_cnt", ferr_seen, 0);

    // Bad parity 0xD6
    cs_fall();
    send_byte(8'hD6, m);
    cs_rise();
    check("d6_miso", m, 8'h0B);
    check("d6_ferr_cnt", ferr_seen, 1);
    check("d6_err_cnt", err_cnt, 1);
    check("d6_pset_cnt", pset_seen, 1);
    check("d6_addr", addr, 5);
    check("d6_level", level, 3);

    // Back-to-back 0x81, 0xFF in one window
    cs_fall();
    send_byte(8'h81, m);
    check("b2b_addr0", addr, 0);
    check("b2b_level0", level, 0);
    send_byte(8'hFF, m2);
    cs_rise();
    check("b2b_miso0", m, 8'h1B);
    check("b2b_miso1", m2, 8'h11);
    check("b2b_pset_cnt", pset_seen, 3);
    check("b2b_addr1", addr, 7);
    check("b2b_level1", level, 7);

    // Truncated frame: 5 bits then CS rise
    cs_fall();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m[i]);
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 check("trunc_early", frame_err, 0);
    @(posedge clk);
    #1 check("trunc_m3", frame_err, 1);
    repeat (8) @(negedge clk);
    check("trunc_err_cnt", err_cnt, 2);
    check("trunc_ferr_cnt", ferr_seen, 2);
    check("trunc_pset_cnt", pset_seen, 3);

    // Valid 0xA5 then 20 bad frames in one window
    cs_fall();
    send_byte(8'hA5, m);
    for (int k = 0; k < 20; k++) send_byte(8'h00, m2);
    cs_rise();
    check("sat_miso_first", m, 8'h2F);
    check("sat_addr", addr, 2);
    check("sat_level", level, 2);
    check("sat_pset_cnt", pset_seen, 4);
    check("sat_err_cnt", err_cnt, 15);
    check("sat_ferr_cnt", ferr_seen, 22);

    cs_fall();
    send_byte(8'h00, m);
    cs_rise();
    check("sat_miso", m, 8'hF5);
    check("sat_err_hold", err_cnt, 15);

    // Reset mid-frame
    cs_fall();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m[i]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_addr", addr, 0);
    check("mrst_level", level, 0);
    check("mrst_err_cnt", err_cnt, 0);
    check("mrst_miso", spi_miso, 0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pset_seen;
    f0 = ferr_seen;
    cs_fall();
    send_byte(8'hB2, m);
    cs_rise();
    check("post_rst_miso", m, 8'h01);
    check("post_rst_addr", addr, 3);
    check("post_rst_level", level, 1);
    check("post_rst_err_cnt", err_cnt, 0);
    check("post_rst_pset", pset_seen - p0, 1);
    check("post_rst_ferr", ferr_seen - f0, 0);

    check("pset_ferr_overlap", both_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_pwm_cmd_rx.md
# spi_pwm_cmd_rx

SPI-slave command receiver that sits directly upstream of the 3-bit, 8-channel PWM driver. It receives 8-bit command frames over a mode-0 SPI link, checks them, and drives the driver's `pset`/`addr`/`level` strobe interface with one pulse per valid frame. It also keeps an error counter and returns a status byte on MISO. SPI inputs are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- `ERR_W`, default 4: width of the saturating bad-frame counter.

Ports:
- `clk`, input, 1: system clock. One clock domain.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `spi_sclk`, input, 1: SPI clock, mode 0 (CPOL=0, CPHA=0). High and low phases are each ≥2 `clk` periods.
- `spi_cs_n`, input, 1: chip select, active-low.
- `spi_mosi`, input, 1: serial data in, MSB first.
- `spi_miso`, output, 1: serial status out, MSB first.
- `pset`, output, 1: one-`clk` pulse to the PWM driver when a valid frame completes.
- `addr`, output, 3: channel address for the driver.
- `level`, output, 3: duty level for the driver.
- `frame_err`, output, 1: one-`clk` pulse when a bad frame is detected.
- `err_cnt`, output, ERR_W: number of bad frames, saturating.

## Operation
- **Synchronizers:** `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer. A third flop on sclk provides edge detection (rise = s2 & ~s3; fall = ~s2 & s3). All logic runs on `clk`.
- **Frame format** (bits [7:0], bit 7 first):
  - [7] = 1: write marker.
  - [6:4] = addr.
  - [3:1] = level.
  - [0] = even parity over [7:1]. The XOR of all 8 bits must be 0.
- **States:**
  - IDLE: CS high.
  - SHIFT: CS low. Each synchronized sclk rise shifts synchronized MOSI into an 8-bit shift register and increments a 3-bit bit counter.
  - When the counter wraps 7→0, the frame is evaluated and SHIFT continues. Back-to-back frames within one CS window are allowed, one frame per 8 bits.
- **Valid frame:** marker=1 and parity OK. Outcome:
  - `addr` and `level` are registered from the frame.
  - `pset` pulses high for one cycle.
  - `addr`/`level` hold their values until the next valid frame.
- **Invalid frame:** marker=0 or parity bad. Outcome:
  - `frame_err` pulses.
  - `err_cnt` increments, saturating at 2^ERR_W−1.
  - `pset`, `addr` and `level` are unchanged.
- **Truncated frame:** synchronized CS rises with the bit counter ≠0. The partial frame is discarded, `frame_err` pulses and `err_cnt` increments. If CS rises with the counter =0, nothing happens.
- **MISO status byte:** `{err_cnt[3:0] (zero-extended/truncated to 4 bits), addr[2:0], 1'b1}`.
  - Loaded on the synchronized CS fall. Bit 7 drives immediately.
  - Shifts on each synchronized sclk fall.
  - Reloads after every 8 bits.
  - `spi_miso` = 0 while CS is high.
- **Reset:**
  - `rst_n` low clears all state asynchronously, including mid-frame.
  - Output reset values: `pset`=0, `addr`=0, `level`=0, `frame_err`=0, `err_cnt`=0, `spi_miso`=0.
  - Synchronizer flops reset to sclk=0, cs_n=1, mosi=0.
  - A frame in progress at reset is lost without an error count.

## Timing
- **Latency:** let N be the first `clk` edge that samples `spi_sclk` high for the 8th bit.
  - Synchronized rise is detected in the cycle after edge N+1.
  - The shift register and counter update at edge N+2.
  - `pset` (or `frame_err`) is high from edge N+3 to edge N+4.
  - `addr`/`level` change at edge N+3, coincident with `pset`.
- **Truncation error** asserts 3 `clk` edges after `spi_cs_n` is first sampled high.
- **Simultaneous events:** if the 8th sclk rise and the CS rise are detected in the same cycle, the frame completes and is evaluated. No truncation error is raised.
- **Output spacing:** at most one `pset` per 8 sclk periods. `pset` and `frame_err` are never high together.
- **MISO timing:** `spi_miso` changes 3 `clk` edges after the sclk fall, which is within the low phase given the ≥2-clk phase rule.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs 0. Release; CS high → no pulses.
- **Valid frame:** send 0xD7 (marker 1, addr 5, level 3, parity 1) → one `pset` pulse; addr=5, level=3 at edge N+3; `err_cnt`=0.
- **Bad parity:** send 0xD6 → `frame_err` pulse, `err_cnt`=1, no `pset`; addr/level keep their previous values (5/3).
- **Back-to-back and truncation:** send 0x81 then 0xFF in one CS window → two `pset` pulses (addr 0/level 0, then addr 7/level 7). Then send 5 bits and raise CS → `frame_err`, `err_cnt`+1.
- **Saturation and MISO:** send 20 bad frames → `err_cnt` stops at 15. Next CS window reads MISO 0xF? (`{4'hF, addr, 1}`) bit-exact.
- **Mid-frame reset:** assert `rst_n` after 4 bits → outputs clear immediately. A following full valid frame is received correctly.
